// File: rtl/effect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : effect_pkg
// Description : Shared definitions for the effect_scan display block:
//               effect mode encodings, default rate divisors, default scan
//               divisor, blank segment code and a small max helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package effect_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_REVEAL = 2'b10,
      MODE_SCROLL = 2'b11
   } mode_t;

   localparam int DEF_SCAN_DIV  = 25000;
   localparam int DEF_RATE_DIV0 = 50000000;
   localparam int DEF_RATE_DIV1 = 25000000;
   localparam int DEF_RATE_DIV2 = 12500000;
   localparam int DEF_RATE_DIV3 = 6250000;

   // Active-low segments: all ones turns every segment off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tick_div
// Description : Terminal-count divisor. Counts 0..div-1 while enabled and
//               asserts tick on the terminal cycle. A count already at or
//               above div-1 (after div shrinks) is treated as terminal, so
//               the tick fires at once rather than running off to overflow.
// Ports       : clk   in  1      clock
//               rst   in  1      asynchronous active-high reset
//               clr   in  1      synchronous clear, suppresses tick
//               en    in  1      count enable
//               div   in  WIDTH  divisor (>= 1)
//               tick  out 1      terminal-count strobe (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] div,
   output logic             tick
);

   logic [WIDTH-1:0] r_count;
   logic             w_term;

   assign w_term = (r_count >= (div - WIDTH'(1)));
   assign tick   = en & ~clr & w_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_term ? '0 : (r_count + WIDTH'(1));
      end
   end

endmodule
`default_nettype wire

// File: rtl/effect_scan.sv
`default_nettype none
// ============================================================================
// Module      : effect_scan
// Description : Multiplexed 7-segment scanner with text effects (static,
//               blink, reveal, scroll). The text is latched into an internal
//               buffer only at frame boundaries, enable rise or mode change,
//               so a sequence never shows a half-updated string.
// Ports       : clk        in  1           system clock
//               rst        in  1           asynchronous active-high reset
//               enable     in  1           run effect; low blanks display
//               mode       in  2           00 static/01 blink/10 reveal/11 scroll
//               rate       in  2           effect step rate select
//               seg_in     in  7*N_DIGITS  active-low codes, digit d at [7d+6:7d]
//               an         out N_DIGITS    active-low one-hot digit select
//               seg        out 7           active-low segments of selected digit
//               frame_done out 1           pulse when the effect sequence wraps
// Revision    : 1.0 - initial release
// ============================================================================
module effect_scan
   import effect_pkg::*;
#(
   parameter int N_DIGITS  = 7,
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int RATE_DIV0 = DEF_RATE_DIV0,
   parameter int RATE_DIV1 = DEF_RATE_DIV1,
   parameter int RATE_DIV2 = DEF_RATE_DIV2,
   parameter int RATE_DIV3 = DEF_RATE_DIV3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [1:0]            rate,
   input  logic [7*N_DIGITS-1:0] seg_in,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic                  frame_done
);

   localparam int SCAN_W   = $clog2(SCAN_DIV + 1);
   localparam int RATE_MAX = max4(RATE_DIV0, RATE_DIV1, RATE_DIV2, RATE_DIV3);
   localparam int RATE_W   = $clog2(RATE_MAX + 1);
   localparam int DIG_W    = $clog2(N_DIGITS);
   // Wide enough to hold digit + step (< 4*N_DIGITS) without wrapping.
   localparam int STEP_W   = $clog2(2 * N_DIGITS) + 1;

   localparam logic [SCAN_W-1:0] C_SCAN_DIV    = SCAN_W'(SCAN_DIV);
   localparam logic [DIG_W-1:0]  C_LAST_DIGIT  = DIG_W'(N_DIGITS - 1);
   localparam logic [STEP_W-1:0] C_N           = STEP_W'(N_DIGITS);
   localparam logic [STEP_W-1:0] C_TWO_N       = STEP_W'(2 * N_DIGITS);
   localparam logic [STEP_W-1:0] C_BLINK_MAX   = STEP_W'(1);
   localparam logic [STEP_W-1:0] C_SCROLL_MAX  = STEP_W'(2 * N_DIGITS - 1);

   mode_t                 r_mode_q;
   logic                  r_en_q;
   logic [DIG_W-1:0]      r_digit;
   logic [STEP_W-1:0]     r_step;
   logic [7*N_DIGITS-1:0] r_buf;

   logic                  w_run;
   logic                  w_mode_chg;
   logic                  w_scan_tick;
   logic                  w_step_tick;
   logic                  w_digit_wrap;
   logic                  w_frame_evt;
   logic                  w_load;
   logic [RATE_W-1:0]     w_rate_div;
   logic [STEP_W-1:0]     w_step_max;
   logic [STEP_W-1:0]     w_sum;
   logic [STEP_W-1:0]     w_idx;
   logic [6:0]            w_code;

   // The first enabled cycle only latches the text; counting starts one
   // cycle later so digit 0 / step 0 are shown with the fresh buffer.
   assign w_run      = enable & r_en_q;
   assign w_mode_chg = (mode_t'(mode) != r_mode_q);

   tick_div #(
      .WIDTH (SCAN_W)
   ) u_scan_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (~w_run),
      .en   (w_run),
      .div  (C_SCAN_DIV),
      .tick (w_scan_tick)
   );

   always_comb begin
      w_rate_div = RATE_W'(RATE_DIV0);
      case (rate)
         2'd0:    w_rate_div = RATE_W'(RATE_DIV0);
         2'd1:    w_rate_div = RATE_W'(RATE_DIV1);
         2'd2:    w_rate_div = RATE_W'(RATE_DIV2);
         default: w_rate_div = RATE_W'(RATE_DIV3);
      endcase
   end

   // Mode change clears the timer and also masks its tick, so a coincident
   // step never advances nor produces a frame pulse.
   tick_div #(
      .WIDTH (RATE_W)
   ) u_rate_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (~w_run | w_mode_chg),
      .en   (w_run),
      .div  (w_rate_div),
      .tick (w_step_tick)
   );

   always_comb begin
      w_step_max = '0;
      case (r_mode_q)
         MODE_BLINK:  w_step_max = C_BLINK_MAX;
         MODE_REVEAL: w_step_max = C_N;
         MODE_SCROLL: w_step_max = C_SCROLL_MAX;
         default:     w_step_max = '0;
      endcase
   end

   assign w_digit_wrap = w_scan_tick & (r_digit == C_LAST_DIGIT);

   always_comb begin
      w_frame_evt = 1'b0;
      if (w_run && !w_mode_chg) begin
         if (r_mode_q == MODE_STATIC)
            w_frame_evt = w_digit_wrap;
         else
            w_frame_evt = w_step_tick & (r_step == w_step_max);
      end
   end

   assign w_load = w_frame_evt | w_mode_chg | (enable & ~r_en_q);

   // Segment code for the current digit under the current effect.
   always_comb begin
      w_code = SEG_BLANK;
      w_sum  = STEP_W'(r_digit) + r_step;
      w_idx  = w_sum % C_TWO_N;
      case (r_mode_q)
         MODE_STATIC: w_code = r_buf[7*int'(r_digit) +: 7];
         MODE_BLINK: begin
            if (r_step == '0)
               w_code = r_buf[7*int'(r_digit) +: 7];
         end
         MODE_REVEAL: begin
            if (STEP_W'(r_digit) < r_step)
               w_code = r_buf[7*int'(r_digit) +: 7];
         end
         default: begin
            // Virtual string: buffer followed by N blanks.
            if (w_idx < C_N)
               w_code = r_buf[7*int'(w_idx) +: 7];
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en_q     <= 1'b0;
         r_mode_q   <= MODE_STATIC;
         r_digit    <= '0;
         r_step     <= '0;
         r_buf      <= {N_DIGITS{SEG_BLANK}};
         an         <= '1;
         seg        <= SEG_BLANK;
         frame_done <= 1'b0;
      end else begin
         r_en_q     <= enable;
         r_mode_q   <= mode_t'(mode);
         frame_done <= w_frame_evt;

         if (w_load)
            r_buf <= seg_in;

         if (!w_run)
            r_digit <= '0;
         else if (w_scan_tick)
            r_digit <= w_digit_wrap ? '0 : (r_digit + DIG_W'(1));

         if (!w_run || w_mode_chg || (r_mode_q == MODE_STATIC))
            r_step <= '0;
         else if (w_step_tick)
            r_step <= (r_step == w_step_max) ? '0 : (r_step + STEP_W'(1));

         if (w_run) begin
            an  <= ~(N_DIGITS'(1) << r_digit);
            seg <= w_code;
         end else begin
            an  <= '1;
            seg <= SEG_BLANK;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/effect_scan.md
EFFECT_SCAN -- requirements
Module: effect_scan

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with all ports as follows.
REQ-002 Parameters SHALL be:
- N_DIGITS, 7, digit count, range 2..16.
- SCAN_DIV, 25000, clk cycles per digit slot.
- RATE_DIV0..RATE_DIV3, 50000000/25000000/12500000/6250000, clk cycles per effect step for rate codes 0..3.
REQ-003 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  run effect; low blanks the display.
- mode  in  2  00 static, 01 blink, 10 reveal, 11 scroll.
- rate  in  2  selects RATE_DIVn.
- seg_in  in  7*N_DIGITS  active-low segment codes; digit d occupies bits [7d+6:7d].
- an  out  N_DIGITS  active-low digit select, one-hot-low.
- seg  out  7  active-low segments for the selected digit.
- frame_done  out  1  one-cycle pulse when the effect sequence wraps.

Function
REQ-004 Scan counter SHALL count 0..SCAN_DIV-1; at terminal count, digit index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-005 an and seg SHALL be registered, reflecting the digit index with exactly 1 cycle latency.
REQ-006 an SHALL drive bit d low only while digit index == d.
REQ-007 Rate timer SHALL count 0..RATE_DIV[rate]-1 and issue an internal step_tick at terminal count.
REQ-008 If rate changes so that timer >= new divisor-1, step_tick SHALL fire on the next cycle.
REQ-009 Step counter range SHALL be: static, held 0; blink, 0..1; reveal, 0..N_DIGITS; scroll, 0..2*N_DIGITS-1.
- step_tick SHALL increment the step counter.
- The step counter SHALL wrap to 0 after the max value.
REQ-010 frame_done SHALL pulse for one cycle on the step_tick that wraps the step to 0; in static mode it SHALL pulse on each digit-index wrap.
REQ-011 Displayed code for digit d SHALL be:
- static: buf[d].
- blink: buf[d] when step==0, else 7'h7F.
- reveal: buf[d] when d < step, else 7'h7F.
- scroll: v[(d+step) mod 2N], where v = buf[0..N-1] followed by N blank codes.
REQ-012 Scroll index arithmetic SHALL be performed at clog2(2*N_DIGITS)+1 bits with explicit modulo; no truncation wrap.
REQ-013 Internal buffer buf SHALL capture all of seg_in on each of these events:
- frame_done;
- enable rising edge;
- any mode change.
REQ-014 buf SHALL otherwise hold, so text never tears mid-sequence.
REQ-015 A mode change SHALL clear the step counter and rate timer in the same cycle; this has priority over a coincident step_tick, and no frame_done is issued.
REQ-016 While enable is low:
- an SHALL be all 1s and seg SHALL be 7'h7F from the next cycle;
- scan, timer and step SHALL hold at 0;
- frame_done SHALL stay 0.
REQ-017 On enable rising, scanning SHALL restart at digit 0, step 0.

Reset
REQ-018 While rst is high, regardless of clk:
- an SHALL be all 1s, seg 7'h7F, frame_done 0;
- scan counter, digit index, timer and step SHALL be 0;
- buf SHALL be all 7'h7F.
REQ-019 Reset asserted mid-operation SHALL abort the current step without a frame_done pulse; after release, operation SHALL begin at digit 0, step 0.

Structure
REQ-020 A shared package effect_pkg SHALL hold:
- mode encodings;
- the four default rate divisors;
- the blank code 7'h7F;
- the default SCAN_DIV.
REQ-021 One sub-module, tick_div, SHALL implement a parametrised-width terminal-count divisor with clear input; it SHALL be used for both the scan and rate timers.
REQ-022 Character-to-segment encoding SHALL remain outside this block.

Verification (N_DIGITS=4, SCAN_DIV=4, RATE_DIV0..3=64/32/16/8)
REQ-023 Reset then enable=1, mode=00, seg_in={7'h12,7'h24,7'h30,7'h79} -> an cycles 1110,1101,1011,0111 every 4 clk; seg follows digit with 1-cycle lag.
REQ-024 mode=01, rate=3 -> digits visible for 8 clk, blank (7'h7F) for 8 clk; frame_done every 16 clk.
REQ-025 mode=10, rate=2 -> step0 all blank; each 16 clk one more digit from digit 0 appears; step4 all visible; then wrap, frame_done, and buf reload.
REQ-026 mode=11, rate=3 -> digit0 shows buf[0..3] then blank over 8 steps; 2N=8 steps per frame_done; seg_in change mid-frame is not displayed until wrap.
REQ-027 Mode change coincident with step_tick -> step=0, no frame_done; rst pulsed mid-reveal -> outputs blank asynchronously; restart at step 0.
REQ-028 enable=0 mid-scroll -> an=1111 next cycle; enable=1 -> digit 0, step 0, buf reloaded.
